// File: rtl/imagenes_lcd.sv
// Purpose: 800x480 parallel-RGB LCD timing generator with a fixed colour-bar / grey-ramp test image.
// Latency: every output is registered; sync, DEN and RGB for a pixel all update on the same pixel tick.
// Backpressure: none, the block is free-running and the panel must accept a pixel on every NCLK.
module imagenes_lcd #(
    parameter int H_TOTAL = 1056,
    parameter int H_BP    = 216,
    parameter int H_ACT   = 800,
    parameter int V_TOTAL = 525,
    parameter int V_BP    = 35,
    parameter int V_ACT   = 480
) (
    input  logic       CLK,
    input  logic       RST_n,
    output logic       NCLK,
    output logic       GREST,
    output logic       HD,
    output logic       VD,
    output logic       DEN,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_START = HW'(H_BP);
    localparam logic [HW-1:0] H_END   = HW'(H_BP + H_ACT);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_START = VW'(V_BP);
    localparam logic [VW-1:0] V_END   = VW'(V_BP + V_ACT);
    localparam logic [VW-1:0] V_HALF  = VW'(V_ACT / 2);

    logic [HW-1:0] h, h_nxt;
    logic [VW-1:0] v, v_nxt;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          den_nxt;
    logic [23:0]   rgb_nxt;
    logic          tick;

    // The pixel tick is the CLK edge on which NCLK falls, so data is settled
    // half a pixel period before the panel samples on NCLK rising.
    assign tick = NCLK;

    // Next raster position and the pixel to be shown there.
    always_comb begin
        h_nxt   = h + HW'(1);
        v_nxt   = v;
        rgb_nxt = 24'h000000;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + VW'(1);
        end
        den_nxt = (h_nxt >= H_START) && (h_nxt < H_END) &&
                  (v_nxt >= V_START) && (v_nxt < V_END);
        x = h_nxt - H_START;
        y = v_nxt - V_START;
        if (den_nxt) begin
            if (y < V_HALF) begin
                // Eight 100-pixel colour bars.
                if      (x < HW'(100)) rgb_nxt = 24'hFFFFFF;
                else if (x < HW'(200)) rgb_nxt = 24'hFFFF00;
                else if (x < HW'(300)) rgb_nxt = 24'h00FFFF;
                else if (x < HW'(400)) rgb_nxt = 24'h00FF00;
                else if (x < HW'(500)) rgb_nxt = 24'hFF00FF;
                else if (x < HW'(600)) rgb_nxt = 24'hFF0000;
                else if (x < HW'(700)) rgb_nxt = 24'h0000FF;
                else                   rgb_nxt = 24'h000000;
            end else begin
                // Grey ramp, 0..199 across the line.
                rgb_nxt = {3{x[9:2]}};
            end
        end
    end

    // Pixel clock divider, panel reset, raster counters and output registers.
    always_ff @(posedge CLK) begin
        if (RST_n) begin
            NCLK  <= 1'b0;
            GREST <= 1'b0;
            HD    <= 1'b1;
            VD    <= 1'b1;
            DEN   <= 1'b0;
            R     <= 8'h00;
            G     <= 8'h00;
            B     <= 8'h00;
            h     <= '0;
            v     <= '0;
        end else begin
            NCLK  <= ~NCLK;
            GREST <= 1'b1;
            if (tick) begin
                h         <= h_nxt;
                v         <= v_nxt;
                HD        <= (h_nxt != '0);
                VD        <= (v_nxt != '0);
                DEN       <= den_nxt;
                {R, G, B} <= rgb_nxt;
            end
        end
    end

endmodule

// File: tb/tb_imagenes_lcd.sv
module tb_imagenes_lcd;

    // Full horizontal geometry; a short frame keeps whole-frame runs affordable.
    localparam int HT = 1056;
    localparam int HB = 216;
    localparam int HA = 800;
    localparam int VT = 8;
    localparam int VB = 2;
    localparam int VA = 4;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b1;
    logic       NCLK, GREST, HD, VD, DEN;
    logic [7:0] R, G, B;

    imagenes_lcd #(
        .H_TOTAL(HT), .H_BP(HB), .H_ACT(HA),
        .V_TOTAL(VT), .V_BP(VB), .V_ACT(VA)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .NCLK(NCLK), .GREST(GREST),
        .HD(HD), .VD(VD), .DEN(DEN), .R(R), .G(G), .B(B)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        int          h;
        int          v;
        logic [26:0] val;   // {HD, VD, DEN, R, G, B}
    } pix_t;

    pix_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Hand-computed spot pixels: {DEN, RGB} at raster position (h, v).
    // Active lines v=2,3 are bars (y=0,1); v=4,5 are grey (y=2,3).
    int          dir_h [0:11] = '{216, 366, 666, 766, 1015, 216, 616, 1015, 215, 1016, 500, 500};
    int          dir_v [0:11] = '{2,   2,   2,   2,   2,    4,   4,   4,    2,   3,    6,   1};
    logic [24:0] dir_x [0:11] = '{
        {1'b1, 24'hFFFFFF}, {1'b1, 24'hFFFF00}, {1'b1, 24'hFF00FF}, {1'b1, 24'hFF0000},
        {1'b1, 24'h000000}, {1'b1, 24'h000000}, {1'b1, 24'h646464}, {1'b1, 24'hC7C7C7},
        {1'b0, 24'h000000}, {1'b0, 24'h000000}, {1'b0, 24'h000000}, {1'b0, 24'h000000}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int x);
        case (x / 100)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected outputs at the n-th NCLK rising edge after reset release.
    // Edge 0 precedes the first pixel tick, so it still shows reset values.
    function automatic pix_t golden(input int n);
        pix_t        p;
        logic        den;
        logic [23:0] rgb;
        int          x, y;
        p.h = n % HT;
        p.v = (n / HT) % VT;
        if (n == 0) begin
            p.val = {1'b1, 1'b1, 1'b0, 24'h000000};
            return p;
        end
        den = (p.h >= HB) && (p.h < HB + HA) && (p.v >= VB) && (p.v < VB + VA);
        x   = p.h - HB;
        y   = p.v - VB;
        rgb = 24'h000000;
        if (den) rgb = (y < VA / 2) ? bar_colour(x) : {3{x[9:2]}};
        p.val = {p.h != 0, p.v != 0, den, rgb};
        return p;
    endfunction

    // Monitor: one expected pixel per panel sampling edge.
    initial begin
        pix_t e;
        forever begin
            @(posedge NCLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({HD, VD, DEN, R, G, B} !== e.val) begin
                    bad++;
                    $display("FAIL pix h=%0d v=%0d got=%h want=%h", e.h, e.v, {HD, VD, DEN, R, G, B}, e.val);
                end
                for (int i = 0; i < 12; i++)
                    if (e.h == dir_h[i] && e.v == dir_v[i])
                        check($sformatf("spot h=%0d v=%0d", e.h, e.v), {7'd0, DEN, R, G, B}, {7'd0, dir_x[i]});
            end
        end
    end

    task automatic drain(input int limit);
        int guard = 0;
        while (exp_q.size() > 0 && guard < limit) begin
            @(posedge CLK);
            guard++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // Stimulus: reset, two full frames, a mid-frame reset and restart.
    initial begin
        RST_n = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        check("rst_outputs", {NCLK, GREST, HD, VD, DEN, R, G, B}, {5'b00110, 24'h000000});

        for (int n = 0; n < 2 * HT * VT + 3000; n++) exp_q.push_back(golden(n));
        @(negedge CLK) RST_n = 1'b0;
        @(posedge CLK);
        #1;
        check("grest_rise", GREST, 1);
        check("nclk_first", NCLK, 1);
        @(posedge CLK);
        #1;
        check("nclk_toggle", NCLK, 0);
        drain(2 * (2 * HT * VT + 3000) + 20);

        // Reset in the middle of a frame.
        @(negedge CLK) RST_n = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_next", {NCLK, GREST, HD, VD, DEN, R, G, B}, {5'b00110, 24'h000000});
        repeat (5) @(posedge CLK);
        #1;
        check("midrst_hold", {NCLK, GREST, HD, VD, DEN, R, G, B}, {5'b00110, 24'h000000});

        for (int n = 0; n < 2 * HT + 50; n++) exp_q.push_back(golden(n));
        @(negedge CLK) RST_n = 1'b0;
        drain(2 * (2 * HT + 50) + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
